// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARMv4 control FSM with NZCV flags, MemReady wait handshake and
// wait-timeout fault. Optional BL support (R14 <= PC+4 via a LINK state) is enabled by defining CU_BL_EN.
module mc_control_unit #(
    parameter int ALUCTRL_W = 4,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           Rd,
    input  logic [1:0]           Op,
    input  logic [1:0]           sh,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Cond,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Link,
    output logic [3:0]           Flags,
    output logic                 Fault
);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, LINK, FAULT
    } state_t;

    state_t        state;
    logic [WW-1:0] wcnt;
    logic          cond_q;
    logic          wait_hit;
    logic          bl;
    logic          rd15;
    logic [3:0]    cmd;
    logic          cmd_ok;
    logic          cv_upd;
    logic          no_wb;
    logic [3:0]    dp_ctl;
    logic [3:0]    ctl;
    logic          pcw;
    logic          irw;
    logic          mwr;
    logic          rwr;

    assign cmd      = Funct[4:1];
    assign rd15     = (Rd == 4'd15);
    assign wait_hit = (MAX_WAIT > 0) && (wcnt == WW'(MAX_WAIT - 1));

`ifdef CU_BL_EN
    assign bl   = Funct[4];
    assign Link = (state == LINK);
`else
    assign bl   = 1'b0;
    assign Link = 1'b0;
`endif

    function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = cy;
            4'b0011: cond_ex = !cy;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = cy && !z;
            4'b1001: cond_ex = !cy || z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = !z && (n == v);
            4'b1101: cond_ex = z || (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    endfunction

    // Data-processing command decode: ALU op, which flags update, and whether a writeback follows
    always_comb begin
        cmd_ok = 1'b1;
        cv_upd = 1'b0;
        no_wb  = 1'b0;
        dp_ctl = 4'b0000;
        case (cmd)
            4'b0100: cv_upd = 1'b1;
            4'b0010: begin dp_ctl = 4'b0001; cv_upd = 1'b1; end
            4'b0000: dp_ctl = 4'b0010;
            4'b1100: dp_ctl = 4'b0011;
            4'b0001: dp_ctl = 4'b0100;
            4'b1010: begin dp_ctl = 4'b0001; cv_upd = 1'b1; no_wb = 1'b1; end
            4'b1000: begin dp_ctl = 4'b0010; no_wb = 1'b1; end
            4'b1101: dp_ctl = Funct[5] ? 4'b0101 : {2'b10, sh};
            default: cmd_ok = 1'b0;
        endcase
    end

    // State sequencing, wait counter, per-instruction condition latch and NZCV register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH;
            wcnt   <= '0;
            cond_q <= 1'b0;
            Flags  <= 4'b0000;
        end else begin
            case (state)
                FETCH, MEMREAD: begin
                    if (MemReady) begin
                        wcnt  <= '0;
                        state <= (state == FETCH) ? DECODE : MEMWB;
                    end else if (wait_hit) begin
                        wcnt  <= '0;
                        state <= FAULT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DECODE: begin
                    cond_q <= cond_ex(Cond, Flags);
                    case (Op)
                        2'b00:   state <= Funct[5] ? EXECI : EXECR;
                        2'b01:   state <= MEMADR;
                        2'b10:   state <= bl ? LINK : BRANCH;
                        default: state <= FAULT;
                    endcase
                end
                MEMADR: state <= Funct[0] ? MEMREAD : MEMWRITE;
                EXECR, EXECI: begin
                    if (cmd_ok && Funct[0] && cond_q)
                        Flags <= cv_upd ? ALUFlags : {ALUFlags[3:2], Flags[1:0]};
                    state <= !cmd_ok ? FAULT : (no_wb ? FETCH : ALUWB);
                end
                LINK:    state <= BRANCH;
                FAULT:   state <= FAULT;
                default: state <= FETCH;
            endcase
        end
    end

    // Datapath controls decoded from the current state, cond_q and MemReady
    always_comb begin
        pcw       = 1'b0;
        irw       = 1'b0;
        mwr       = 1'b0;
        rwr       = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ImmSrc    = 2'b00;
        RegSrc    = 2'b00;
        ctl       = 4'b0000;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = MemReady;
                pcw       = MemReady;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                RegSrc[1] = (Op == 2'b01) && !Funct[0];
            end
            MEMADR: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b01;
                RegSrc[1] = !Funct[0];
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                RegSrc[1] = 1'b1;
                mwr       = cond_q;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                rwr       = cond_q && !rd15;
                pcw       = cond_q && rd15;
            end
            EXECR, EXECI: begin
                ALUSrcB = (state == EXECI) ? 2'b01 : 2'b00;
                ctl     = dp_ctl;
            end
            ALUWB: begin
                rwr = cond_q && !rd15;
                pcw = cond_q && rd15;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                ResultSrc = 2'b10;
                RegSrc[0] = 1'b1;
                pcw       = cond_q;
            end
            LINK: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b11;
                ResultSrc = 2'b10;
                rwr       = cond_q;
            end
            default: ;
        endcase
    end

    assign PCWrite    = rst && pcw;
    assign IRWrite    = rst && irw;
    assign MemWrite   = rst && mwr;
    assign RegWrite   = rst && rwr;
    assign Fault      = (state == FAULT);
    assign ALUControl = ALUCTRL_W'(ctl);
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized per-instruction reference model of the multicycle control unit.
module tb_mc_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] Rd = '0, Cond = '0, ALUFlags = '0;
    logic [1:0] Op = '0, sh = '0;
    logic [5:0] Funct = '0;
    logic       MemReady = 1'b0;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA, Link, Fault;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0] ALUControl, Flags;

    int checks = 0;
    int errors = 0;
    logic [3:0] mflags = '0;

    typedef struct {
        int          mr;
        logic [17:0] e;
    } step_t;
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];

    wire [17:0] obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                       ALUSrcB, ImmSrc, ALUControl, Link, Fault};

    mc_control_unit #(.ALUCTRL_W(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Op(Op), .sh(sh), .Funct(Funct), .Cond(Cond),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .Link(Link), .Flags(Flags), .Fault(Fault)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] ev(input int pcw, adr, irw, mw, rw, rs, sa, sb, is, ac, lk, ft);
        return {pcw[0], adr[0], irw[0], mw[0], rw[0], rs[1:0], sa[0], sb[1:0], is[1:0], ac[3:0], lk[0], ft[0]};
    endfunction

    // ARM condition: pairs of codes share a base predicate, odd code inverts it
    function automatic int cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic [6:0] base;
        if (c == 4'hF) return 0;
        if (c == 4'hE) return 1;
        base = {!f[2] && (f[3] == f[0]), f[3] == f[0], f[1] && !f[2], f[0], f[3], f[1], f[2]};
        return int'(base[c[3:1]] ^ c[0]);
    endfunction

    function automatic int alu_of(input logic [3:0] cmd, input logic i, input logic [1:0] s);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            4'b0001: return 4;
            4'b1010: return 1;
            4'b1000: return 2;
            4'b1101: return i ? 5 : 8 + int'(s);
            default: return -1;
        endcase
    endfunction

    // Builds the expected per-cycle control trace of one instruction, drives it and records observations
    task automatic run(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] cnd, rd,
                       input logic [1:0] s, input int fw, mwt, input logic [3:0] af, output bit flt);
        step_t q[$];
        int c, r15, ac;
        Op = op; Funct = fn; Cond = cnd; Rd = rd; sh = s; ALUFlags = af;
        c = cond_ok(cnd, mflags);
        r15 = (rd == 4'd15) ? 1 : 0;
        flt = 1'b0;
        repeat (fw) q.push_back('{0, ev(0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0)});
        q.push_back('{1, ev(1, 0, 1, 0, 0, 2, 1, 2, 0, 0, 0, 0)});
        q.push_back('{2, ev(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0)});
        if (op == 2'b00) begin
            ac = alu_of(fn[4:1], fn[5], s);
            q.push_back('{2, ev(0, 0, 0, 0, 0, 0, 0, fn[5] ? 1 : 0, 0, ac < 0 ? 0 : ac, 0, 0)});
            if (ac < 0) flt = 1'b1;
            else begin
                if (fn[0] && c == 1)
                    mflags = (fn[4:1] inside {4'b0100, 4'b0010, 4'b1010}) ? af : {af[3:2], mflags[1:0]};
                if (!(fn[4:1] inside {4'b1010, 4'b1000}))
                    q.push_back('{2, ev(c & r15, 0, 0, 0, c & ~r15, 0, 0, 0, 0, 0, 0, 0)});
            end
        end else if (op == 2'b01) begin
            q.push_back('{2, ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0)});
            if (fn[0]) begin
                repeat (mwt) q.push_back('{0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
                q.push_back('{1, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
                q.push_back('{2, ev(c & r15, 0, 0, 0, c & ~r15, 1, 0, 0, 0, 0, 0, 0)});
            end else
                q.push_back('{2, ev(0, 1, 0, c, 0, 0, 0, 0, 0, 0, 0, 0)});
        end else if (op == 2'b10) begin
`ifdef CU_BL_EN
            if (fn[4]) q.push_back('{2, ev(0, 0, 0, 0, c, 2, 1, 3, 0, 0, 1, 0)});
`endif
            q.push_back('{2, ev(c, 0, 0, 0, 0, 2, 0, 1, 2, 0, 0, 0)});
        end else
            flt = 1'b1;
        if (flt) q.push_back('{2, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        foreach (q[i]) begin
            MemReady = (q[i].mr == 2) ? 1'($urandom) : q[i].mr[0];
            @(negedge clk);
            exp_q.push_back(q[i].e);
            got_q.push_back(obs);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mflags = '0;
    endtask

    task automatic clear();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_enables got=%b exp=0000", {PCWrite, IRWrite, MemWrite, RegWrite});
        end
        checks++;
        if ({Fault, Flags, Link} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state got fault=%b flags=%b link=%b exp all 0", Fault, Flags, Link);
        end
        rst = 1'b1;
    endtask

    task automatic test_add_imm();
        bit f;
        clear();
        run(2'b00, 6'b101000, 4'hE, 4'd1, 2'b00, 0, 0, 4'($urandom), f);
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL add_imm cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (got_q.size() != 4 || got_q[3][13] !== 1'b1 || got_q[2][5:2] !== 4'b0000) begin
            errors++;
            $display("FAIL add_imm_directed len=%0d exp 4 with RegWrite=1 in cycle 4, ALUControl=0000", got_q.size());
        end
    endtask

    task automatic test_subs_beq();
        bit f;
        clear();
        pulse_reset();
        run(2'b00, 6'b000101, 4'hE, 4'd2, 2'b00, 0, 0, 4'b0100, f);
        checks++;
        if (Flags !== 4'b0100) begin errors++; $display("FAIL subs_flags got=%b exp=0100", Flags); end
        run(2'b10, 6'b000000, 4'h0, 4'd0, 2'b00, 0, 0, 4'b0000, f);
        run(2'b10, 6'b000000, 4'h1, 4'd0, 2'b00, 0, 0, 4'b0000, f);
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL subs_beq cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (got_q[6][17] !== 1'b1 || got_q[9][17] !== 1'b0) begin
            errors++;
            $display("FAIL beq_bne_pcwrite got beq=%b bne=%b exp 1 0", got_q[6][17], got_q[9][17]);
        end
    endtask

    task automatic test_ldr_wait();
        bit f;
        clear();
        run(2'b01, 6'b011001, 4'hE, 4'd3, 2'b00, 0, 3, 4'b0000, f);
        run(2'b01, 6'b011001, 4'hE, 4'd15, 2'b00, 0, 0, 4'b0000, f);
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ldr_wait cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (got_q[7][12:11] !== 2'b01 || got_q[12][17] !== 1'b1 || got_q[12][13] !== 1'b0) begin
            errors++;
            $display("FAIL ldr_wb got rs=%b pcw=%b rw=%b exp rs=01 pcw=1 rw=0", got_q[7][12:11], got_q[12][17], got_q[12][13]);
        end
    endtask

    task automatic test_timeout();
        bit f;
        pulse_reset();
        for (int k = 1; k <= 15; k++) begin
            MemReady = 1'b0;
            @(negedge clk);
            checks++;
            if (Fault !== 1'b0 || IRWrite !== 1'b0) begin errors++; $display("FAIL timeout_early cyc%0d fault=%b exp 0", k, Fault); end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            MemReady = 1'b1;
            @(negedge clk);
            checks++;
            if ({Fault, PCWrite, IRWrite, MemWrite, RegWrite} !== 5'b10000) begin
                errors++;
                $display("FAIL timeout_fault got=%b exp=10000", {Fault, PCWrite, IRWrite, MemWrite, RegWrite});
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (Fault !== 1'b0) begin errors++; $display("FAIL timeout_reset fault got=%b exp 0", Fault); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        mflags = '0;
        clear();
        run(2'b00, 6'b101000, 4'hE, 4'd1, 2'b00, 0, 0, 4'b0000, f);
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_recover cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_movs_cmp();
        bit f;
        clear();
        pulse_reset();
        run(2'b00, 6'b001001, 4'hE, 4'd1, 2'b00, 0, 0, 4'b0011, f);
        run(2'b00, 6'b011011, 4'hE, 4'd0, 2'b01, 0, 0, 4'b1100, f);
        checks++;
        if (Flags !== 4'b1111) begin errors++; $display("FAIL movs_flags got=%b exp=1111", Flags); end
        run(2'b00, 6'b010101, 4'hE, 4'd0, 2'b00, 0, 0, 4'b0000, f);
        checks++;
        if (Flags !== 4'b0000) begin errors++; $display("FAIL cmp_flags got=%b exp=0000", Flags); end
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL movs_cmp cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (got_q[6][5:2] !== 4'b1001 || got_q.size() != 11 || got_q[10][13] !== 1'b0) begin
            errors++;
            $display("FAIL movs_ctl got=%b len=%0d exp ctl=1001 len=11", got_q[6][5:2], got_q.size());
        end
    endtask

    task automatic test_bl();
        bit f;
        clear();
        run(2'b10, 6'b010000, 4'hE, 4'd0, 2'b00, 0, 0, 4'b0000, f);
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bl cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
        checks++;
`ifdef CU_BL_EN
        if (got_q.size() != 4 || got_q[2][1] !== 1'b1 || got_q[2][13] !== 1'b1 || got_q[3][17] !== 1'b1) begin
            errors++;
            $display("FAIL bl_link len=%0d exp 4 with Link/RegWrite then PCWrite", got_q.size());
        end
`else
        if (got_q.size() != 3 || got_q[2][1] !== 1'b0 || got_q[2][17] !== 1'b1) begin
            errors++;
            $display("FAIL bl_as_b len=%0d exp 3, Link=0, PCWrite=1", got_q.size());
        end
`endif
    endtask

    task automatic test_faults();
        bit f;
        clear();
        run(2'b11, 6'b000000, 4'hE, 4'd0, 2'b00, 0, 0, 4'b0000, f);
        pulse_reset();
        run(2'b00, 6'b000111, 4'hE, 4'd0, 2'b00, 0, 0, 4'b1111, f);
        pulse_reset();
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL faults cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit f;
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd4; Cond = 4'hE; MemReady = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        checks++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite, Fault, Flags} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid got=%b exp all 0", {PCWrite, IRWrite, MemWrite, RegWrite, Fault, Flags});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        mflags = '0;
        clear();
        run(2'b00, 6'b101000, 4'hE, 4'd1, 2'b00, 0, 0, 4'b0000, f);
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_mid_next cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [3:0] good [8] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000, 4'b1101};
        logic [3:0] bad  [8] = '{4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1011, 4'b1110, 4'b1111};
        logic [1:0] op;
        logic [5:0] fn;
        int fw, mwt, r;
        bit f;
        clear();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            op = (r < 55) ? 2'b00 : (r < 80) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
            fn = 6'($urandom);
            if (op == 2'b00) fn[4:1] = ($urandom_range(0, 19) == 0) ? bad[$urandom_range(0, 7)] : good[$urandom_range(0, 7)];
            fw  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 2);
            mwt = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
            run(op, fn, 4'($urandom), 4'($urandom), 2'($urandom), fw, mwt, 4'($urandom), f);
            checks++;
            if (Flags !== mflags) begin errors++; $display("FAIL rand_flags instr%0d got=%b exp=%b", n, Flags, mflags); end
            if (f) pulse_reset();
        end
        foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand cyc%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_subs_beq();
        test_ldr_wait();
        test_timeout();
        test_movs_cmp();
        test_bl();
        test_faults();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
